onewire_temp_slave: RTL
=======================

ONEWIRE_TEMP_SLAVE -- requirements
Module: onewire_temp_slave

Interface
REQ-001 SHALL have parameter CONV_CYCLES, default 750000: conversion time in clk cycles (750 ms at 1 MHz).
REQ-002 SHALL have parameter SLOT_SAMPLE, default 30: cycles from slot falling edge to write-bit sample and read-0 hold length.
REQ-003 clk  input  1  system clock, 1 MHz (1 cycle = 1 us).
REQ-004 ARst  input  1  reset, asynchronous, active-high.
REQ-005 DIn  input  1  sampled 1-Wire bus level (1 = released/high).
REQ-006 DOut  output  1  bus pull-down enable (1 = drive bus low, 0 = release).
REQ-007 temp  input  16  sensor value in DS18B20 format (signed, 1/16 degC LSB), latched on Convert T.
REQ-008 conv_busy  output  1  high while a conversion is in progress.
REQ-009 cmd_err  output  1  one-cycle pulse on an unsupported ROM or function command.

Function
REQ-010 DIn SHALL pass through a 2-FF synchronizer; all timing below counts from the synchronized edge.
REQ-011 Reset detect: DIn low for >= 480 consecutive cycles, then high, SHALL enter PRES_WAIT from any state, aborting any transaction; conv_busy and an ongoing conversion are not aborted.
REQ-012 PRES_WAIT: 30 cycles after the rising edge SHALL assert DOut for exactly 120 cycles (PRESENCE), then release and enter ROM_CMD.
REQ-013 Write slot: each DIn falling edge in ROM_CMD/FUNC_CMD SHALL sample DIn SLOT_SAMPLE cycles later; bits shift in LSB first; 8 bits form one command byte.
REQ-014 ROM_CMD: 0xCC (Skip ROM) -> FUNC_CMD; any other byte -> cmd_err pulse, IDLE (ignore bus until next reset).
REQ-015 FUNC_CMD: 0x44 -> latch temp into scratchpad bytes 0/1, start conversion, enter CONV; 0xBE -> TX_SCRATCH at byte index 0, bit 0; other -> cmd_err pulse, IDLE.
REQ-016 Read slot: on DIn falling edge in CONV/TX_SCRATCH, if the current bit is 0 SHALL assert DOut for SLOT_SAMPLE cycles starting the cycle after the synchronized edge; if 1, DOut stays 0.
REQ-017 CONV: conv_busy high for CONV_CYCLES cycles; read slots return 0 while busy, 1 when done; CONV persists until bus reset.
REQ-018 Scratchpad SHALL be 9 bytes sent LSB first: temp[7:0], temp[15:8], 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, CRC.
REQ-019 CRC SHALL be Dallas CRC-8 (poly x^8+x^5+x^4+1, init 0x00, LSB-first) over bytes 0-7, computed bitwise while transmitting or before byte 8 is sent.
REQ-020 After byte 8 (72 read slots) further read slots SHALL return 1 (bus released).
REQ-021 Falling edges occurring during PRESENCE or while DOut is self-asserted SHALL NOT be treated as slot starts.
REQ-022 A slot in progress interrupted by a low period >= 480 cycles SHALL be discarded and treated as a reset per REQ-011.
REQ-023 Convert T issued while conv_busy SHALL restart the counter and re-latch temp.

Reset
REQ-024 ARst SHALL asynchronously force state IDLE, DOut=0, conv_busy=0, cmd_err=0, counters and bit/byte indices 0, scratchpad temp bytes 0x0550 (85 degC), synchronizer flops 1.
REQ-025 Release of ARst SHALL require a bus reset before any response; no presence pulse without a prior >= 480-cycle low.

Verification
REQ-026 Bus low 500 cycles then high -> DOut rises 30(+2 sync) cycles later, held exactly 120 cycles; low of 400 cycles -> no presence.
REQ-027 Reset, write 0xCC, 0x44 with temp=0x0191, CONV_CYCLES=100 -> conv_busy high 100 cycles; read slots return 0 during, 1 after.
REQ-028 Reset, 0xCC, 0xBE after REQ-027 -> 72 read slots yield 0x91,0x01,0x4B,0x46,0x7F,0xFF,0x0C,0x10,correct CRC; slot 73 returns 1.
REQ-029 Reset, write 0x33 -> cmd_err one-cycle pulse, subsequent slots get no response until next reset.
REQ-030 Reset mid-TX_SCRATCH (after 12 bits) -> presence pulse, fresh 0xCC/0xBE restarts at byte 0 bit 0; ARst mid-presence -> DOut=0 immediately, temp bytes 0x0550.

Source files
------------

// File: rtl/onewire_temp_slave_if.sv
// 1-Wire temperature slave signal bundle: bus sample/drive, sensor value,
// status outputs and an FSM debug tap.
interface onewire_temp_slave_if;
  logic        DIn;        // sampled bus level, 1 = released/high
  logic        DOut;       // 1 = pull bus low
  logic [15:0] temp;       // sensor value, DS18B20 format
  logic        conv_busy;  // conversion in progress
  logic        cmd_err;    // one-cycle pulse on unsupported command
  logic [2:0]  dbg_state;  // current FSM state encoding

  modport master (
    output DIn, temp,
    input  DOut, conv_busy, cmd_err, dbg_state
  );

  modport slave (
    input  DIn, temp,
    output DOut, conv_busy, cmd_err, dbg_state
  );
endinterface

// File: rtl/onewire_temp_slave.sv
// Minimal DS18B20-style 1-Wire slave: bus reset/presence, Skip ROM,
// Convert T (0x44) and Read Scratchpad (0xBE) with Dallas CRC-8.
//
// Handshake note: the 1-Wire bus has no valid/ready; the master owns
// every slot. A slot begins on a synchronized falling edge of DIn that the
// slave did not cause itself. Write slots are sampled SLOT_SAMPLE cycles
// after that edge; read slots answer a 0 by holding DOut for SLOT_SAMPLE
// cycles starting the cycle after the edge. A low period of >= 480 cycles
// followed by a rising edge is a bus reset and overrides everything else.
module onewire_temp_slave #(
  parameter int CONV_CYCLES = 750000,
  parameter int SLOT_SAMPLE = 30
) (
  input  logic                  clk,
  input  logic                  ARst,
  onewire_temp_slave_if.slave   bus
);

  localparam int SW = $clog2(SLOT_SAMPLE + 1);
  localparam int CW = $clog2(CONV_CYCLES + 1);

  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_SAMPLE);
  localparam logic [CW-1:0] CONV_LOAD  = CW'(CONV_CYCLES - 1);
  localparam logic [8:0]    RESET_LOW  = 9'd480;
  // DOut must rise 30 cycles after the synchronized rising edge; the edge
  // is seen one cycle late and DOut is registered, hence 28.
  localparam logic [6:0]    PRES_DELAY_LAST = 7'd28;
  localparam logic [6:0]    PRES_LEN_LAST   = 7'd119;

  localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
  localparam logic [7:0] CMD_CONVERT_T = 8'h44;
  localparam logic [7:0] CMD_READ_SP   = 8'hBE;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRES_WAIT  = 3'd1,
    ST_PRESENCE   = 3'd2,
    ST_ROM_CMD    = 3'd3,
    ST_FUNC_CMD   = 3'd4,
    ST_CONV       = 3'd5,
    ST_TX_SCRATCH = 3'd6
  } state_e;

  // Synchronizer and edge detection
  logic       din_s1_q, din_s2_q, din_prev_q;
  logic [8:0] low_cnt_q, low_cnt_d;
  logic       fall, rise, bus_reset;

  // Protocol state
  state_e          state_q, state_d;
  logic [6:0]      timer_q, timer_d;
  logic            slot_act_q, slot_act_d;
  logic [SW-1:0]   slot_cnt_q, slot_cnt_d;
  logic            dout_q, dout_d;
  logic [7:0]      shift_q, shift_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [3:0]      byte_idx_q, byte_idx_d;
  logic [7:0]      crc_q, crc_d;
  logic [7:0]      sp_lo_q, sp_lo_d;
  logic [7:0]      sp_hi_q, sp_hi_d;
  logic            conv_busy_q, conv_busy_d;
  logic [CW-1:0]   conv_cnt_q, conv_cnt_d;
  logic            cmd_err_q, cmd_err_d;

  logic [7:0]      sp_byte;
  logic            sp_bit;
  logic [7:0]      crc_next;

  // Two-flop synchronizer, edge history and low-time counter
  always_ff @(posedge clk or posedge ARst) begin
    if (ARst) begin
      din_s1_q   <= 1'b1;
      din_s2_q   <= 1'b1;
      din_prev_q <= 1'b1;
      low_cnt_q  <= '0;
    end else begin
      din_s1_q   <= bus.DIn;
      din_s2_q   <= din_s1_q;
      din_prev_q <= din_s2_q;
      low_cnt_q  <= low_cnt_d;
    end
  end

  // Count consecutive synchronized-low cycles, saturating at the reset length
  always_comb begin
    low_cnt_d = low_cnt_q;
    if (din_s2_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != RESET_LOW) begin
      low_cnt_d = low_cnt_q + 9'd1;
    end
  end

  assign fall      = din_prev_q & ~din_s2_q;
  assign rise      = ~din_prev_q & din_s2_q;
  assign bus_reset = rise & (low_cnt_q == RESET_LOW);

  // Scratchpad byte currently being transmitted; byte 8 is the running CRC
  always_comb begin
    sp_byte = 8'hFF;
    case (byte_idx_q)
      4'd0:    sp_byte = sp_lo_q;
      4'd1:    sp_byte = sp_hi_q;
      4'd2:    sp_byte = 8'h4B;
      4'd3:    sp_byte = 8'h46;
      4'd4:    sp_byte = 8'h7F;
      4'd5:    sp_byte = 8'hFF;
      4'd6:    sp_byte = 8'h0C;
      4'd7:    sp_byte = 8'h10;
      4'd8:    sp_byte = crc_q;
      default: sp_byte = 8'hFF;
    endcase
  end

  assign sp_bit   = sp_byte[bit_idx_q];
  // Dallas CRC-8, reflected form of x^8+x^5+x^4+1
  assign crc_next = {1'b0, crc_q[7:1]} ^ ((crc_q[0] ^ sp_bit) ? 8'h8C : 8'h00);

  // State and datapath registers
  always_ff @(posedge clk or posedge ARst) begin
    if (ARst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      slot_act_q  <= 1'b0;
      slot_cnt_q  <= '0;
      dout_q      <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      crc_q       <= '0;
      sp_lo_q     <= 8'h50;
      sp_hi_q     <= 8'h05;
      conv_busy_q <= 1'b0;
      conv_cnt_q  <= '0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      slot_act_q  <= slot_act_d;
      slot_cnt_q  <= slot_cnt_d;
      dout_q      <= dout_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      crc_q       <= crc_d;
      sp_lo_q     <= sp_lo_d;
      sp_hi_q     <= sp_hi_d;
      conv_busy_q <= conv_busy_d;
      conv_cnt_q  <= conv_cnt_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  // Next-state, slot timing, command decode and conversion timer
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    slot_act_d  = slot_act_q;
    slot_cnt_d  = slot_cnt_q;
    dout_d      = dout_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    crc_d       = crc_q;
    sp_lo_d     = sp_lo_q;
    sp_hi_d     = sp_hi_q;
    conv_busy_d = conv_busy_q;
    conv_cnt_d  = conv_cnt_q;
    cmd_err_d   = 1'b0;

    // The conversion runs independently of bus resets.
    if (conv_busy_q) begin
      if (conv_cnt_q == '0) begin
        conv_busy_d = 1'b0;
      end else begin
        conv_cnt_d = conv_cnt_q - CW'(1);
      end
    end

    if (bus_reset) begin
      // Abort any transaction, including a slot in progress.
      state_d    = ST_PRES_WAIT;
      timer_d    = '0;
      slot_act_d = 1'b0;
      slot_cnt_d = '0;
      dout_d     = 1'b0;
      shift_d    = '0;
      bit_idx_d  = '0;
      byte_idx_d = '0;
      crc_d      = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // Ignore the bus until the next reset.
        end

        ST_PRES_WAIT: begin
          if (timer_q == PRES_DELAY_LAST) begin
            state_d = ST_PRESENCE;
            timer_d = '0;
            dout_d  = 1'b1;
          end else begin
            timer_d = timer_q + 7'd1;
          end
        end

        ST_PRESENCE: begin
          if (timer_q == PRES_LEN_LAST) begin
            state_d = ST_ROM_CMD;
            timer_d = '0;
            dout_d  = 1'b0;
          end else begin
            timer_d = timer_q + 7'd1;
          end
        end

        ST_ROM_CMD, ST_FUNC_CMD: begin
          if (slot_act_q) begin
            if (slot_cnt_q == SLOT_LAST) begin
              slot_act_d = 1'b0;
              slot_cnt_d = '0;
              shift_d    = {din_s2_q, shift_q[7:1]};
              bit_idx_d  = bit_idx_q + 3'd1;
              if (bit_idx_q == 3'd7) begin
                if (state_q == ST_ROM_CMD) begin
                  if (shift_d == CMD_SKIP_ROM) begin
                    state_d = ST_FUNC_CMD;
                  end else begin
                    state_d   = ST_IDLE;
                    cmd_err_d = 1'b1;
                  end
                end else if (shift_d == CMD_CONVERT_T) begin
                  // Also restarts a conversion already in flight.
                  state_d     = ST_CONV;
                  sp_lo_d     = bus.temp[7:0];
                  sp_hi_d     = bus.temp[15:8];
                  conv_busy_d = 1'b1;
                  conv_cnt_d  = CONV_LOAD;
                end else if (shift_d == CMD_READ_SP) begin
                  state_d    = ST_TX_SCRATCH;
                  byte_idx_d = '0;
                  bit_idx_d  = '0;
                  crc_d      = '0;
                end else begin
                  state_d   = ST_IDLE;
                  cmd_err_d = 1'b1;
                end
              end
            end else begin
              slot_cnt_d = slot_cnt_q + SW'(1);
            end
          end else if (fall && !dout_q) begin
            slot_act_d = 1'b1;
            slot_cnt_d = SW'(1);
          end
        end

        ST_CONV, ST_TX_SCRATCH: begin
          if (slot_act_q) begin
            if (slot_cnt_q == SLOT_LAST) begin
              slot_act_d = 1'b0;
              slot_cnt_d = '0;
              dout_d     = 1'b0;
            end else begin
              slot_cnt_d = slot_cnt_q + SW'(1);
            end
          end else if (fall && !dout_q) begin
            slot_act_d = 1'b1;
            slot_cnt_d = SW'(1);
            if (state_q == ST_CONV) begin
              // Busy reads as 0, done as 1.
              dout_d = conv_busy_q;
            end else if (byte_idx_q < 4'd9) begin
              dout_d    = ~sp_bit;
              bit_idx_d = bit_idx_q + 3'd1;
              if (byte_idx_q < 4'd8) begin
                crc_d = crc_next;
              end
              if (bit_idx_q == 3'd7) begin
                byte_idx_d = byte_idx_q + 4'd1;
              end
            end else begin
              // Past the CRC byte the bus stays released.
              dout_d = 1'b0;
            end
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign bus.DOut      = dout_q;
  assign bus.conv_busy = conv_busy_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.dbg_state = state_q;

endmodule
